cp_xf_load_unit: RTL and testbench

- Command-processor stage directly upstream of the XF top.
- Executes "load XF registers" commands: the CP opcode decoder hands over after recognising opcode 0x10; this block consumes the following byte stream.
- Assembles the 32-bit header and the data words from that stream, then drives the XF CP write bus (CPAddr/CPWrite/CPWriteData) with one write per data word at auto-incrementing addresses.
- The XF always accepts writes, so there is no backpressure on the output side.

---
 rtl/cp_xf_load_unit_pkg.sv | 27 ++
 rtl/cp_xf_load_unit_if.sv | 42 ++++
 rtl/cp_xf_load_unit_byte_packer.sv | 46 ++++
 rtl/cp_xf_load_unit.sv | 120 ++++++++++++
 tb/tb_cp_xf_load_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_xf_load_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp_pkg : shared definitions for the CP "load XF registers" command path.
//   - state_t        : load-unit FSM states (IDLE / HDR / DATA)
//   - XF_LOAD_OPCODE : CP opcode that hands control to the load unit
//   - HDR_*          : bit positions of the count and address header fields
//   - BYTE_CNT_W     : width of the byte-in-word counter of the byte packer
// -----------------------------------------------------------------------------
package cp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0] XF_LOAD_OPCODE = 8'h10;

  // Header word layout: {count-minus-one, start address}
  localparam int HDR_CNT_MSB  = 31;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_ADDR_MSB = 15;
  localparam int HDR_ADDR_LSB = 0;

  // Four bytes per 32-bit word
  localparam int BYTE_CNT_W = 2;

endpackage

// File: rtl/cp_xf_load_unit_if.sv
// -----------------------------------------------------------------------------
// cp_xf_load_unit_if : command-stream input and XF CP write bus of the load unit.
//   start        : one-cycle pulse from the opcode decoder (opcode 0x10 seen)
//   in_data      : command stream byte
//   in_valid     : in_data valid
//   in_ready     : load unit can take a byte
//   busy         : command in progress
//   done         : pulse coincident with the final CPWrite of a command
//   CPAddr       : XF register address
//   CPWrite      : one-cycle write strobe
//   CPWriteData  : write data
//
// Handshake: a byte transfers on a rising clock edge where in_valid and
// in_ready are both high. in_valid may be raised or dropped at any time and
// in_ready does not depend on in_valid. The CP write side has no
// backpressure: CPAddr/CPWriteData are meaningful only while CPWrite is high.
//
// Modports: slave = the load unit, master = the command source / XF observer.
// -----------------------------------------------------------------------------
interface cp_xf_load_unit_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] CPAddr;
  logic              CPWrite;
  logic [31:0]       CPWriteData;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, busy, done, CPAddr, CPWrite, CPWriteData
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, busy, done, CPAddr, CPWrite, CPWriteData
  );
endinterface

// File: rtl/cp_xf_load_unit_byte_packer.sv
// -----------------------------------------------------------------------------
// cp_byte_packer : 8 -> 32 bit big-endian word assembler.
//   clk, resetn   : clock, asynchronous active-low reset
//   i_data        : input byte
//   i_valid       : input byte valid
//   i_ready       : consumer is accepting bytes (transfer = i_valid & i_ready)
//   o_word        : assembled word, valid only while o_word_valid is high
//   o_word_valid  : pulse in the cycle the fourth byte of a word is accepted
//
// The first accepted byte lands in bits 31:24. The fourth byte is forwarded
// combinationally so the consumer can register the complete word on the same
// edge that accepts it.
// -----------------------------------------------------------------------------
module cp_byte_packer
  import cp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [BYTE_CNT_W-1:0] r_cnt;
  logic [23:0]           r_shift;
  logic                  w_accept;

  assign w_accept = i_valid & i_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= {r_shift[15:0], i_data};
      // Counter wraps 3 -> 0 naturally, starting the next word.
      r_cnt   <= r_cnt + BYTE_CNT_W'(1);
    end
  end

  assign o_word       = {r_shift, i_data};
  assign o_word_valid = w_accept && (r_cnt == '1);

endmodule

// File: rtl/cp_xf_load_unit.sv
// -----------------------------------------------------------------------------
// cp_xf_load_unit : executes CP "load XF registers" commands.
//   clk          : system clock
//   resetn       : asynchronous active-low reset
//   bus          : cp_xf_load_unit_if.slave (command stream in, XF write out)
//   o_dbg_state  : current FSM state (cp_pkg::state_t encoding)
//
// After a start pulse the unit takes a 4-byte big-endian header
// {count-1[31:16], addr[15:0]} followed by count 4-byte data words. Each data
// word produces one CPWrite the cycle after its last byte is accepted, at an
// address that auto-increments (modulo 2^ADDR_W). The final write carries
// done, and the unit is back in IDLE with in_ready low in that same cycle.
// start is only honoured in IDLE. All outputs are registered.
// -----------------------------------------------------------------------------
module cp_xf_load_unit
  import cp_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  cp_xf_load_unit_if.slave      bus,
  output logic [1:0]            o_dbg_state
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_cp_write;
  logic [ADDR_W-1:0] r_cp_addr;
  logic [31:0]       r_cp_data;
  logic [CNT_W-1:0]  r_cnt_rem;
  logic [ADDR_W-1:0] r_addr;

  logic [31:0]       w_word;
  logic              w_word_valid;

  // One packer serves both header and data phases; in IDLE in_ready is low
  // so it never sees a byte outside a command.
  cp_byte_packer u_packer (
    .clk          (clk),
    .resetn       (resetn),
    .i_data       (bus.in_data),
    .i_valid      (bus.in_valid),
    .i_ready      (r_in_ready),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cp_write <= 1'b0;
      r_cp_addr  <= '0;
      r_cp_data  <= '0;
      r_cnt_rem  <= '0;
      r_addr     <= '0;
    end else begin
      r_cp_write <= 1'b0;
      r_done     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_HDR;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        ST_HDR: begin
          if (w_word_valid) begin
            r_cnt_rem <= w_word[HDR_CNT_LSB +: CNT_W];
            r_addr    <= w_word[HDR_ADDR_LSB +: ADDR_W];
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_word_valid) begin
            r_cp_write <= 1'b1;
            r_cp_data  <= w_word;
            r_cp_addr  <= r_addr;
            r_addr     <= r_addr + ADDR_W'(1);
            // Count holds N-1, so zero before decrement marks the last word;
            // this lets 0xFFFF encode 65536 words without an extra bit.
            if (r_cnt_rem == '0) begin
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_cnt_rem <= r_cnt_rem - CNT_W'(1);
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.CPWrite     = r_cp_write;
  assign bus.CPAddr      = r_cp_addr;
  assign bus.CPWriteData = r_cp_data;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cp_xf_load_unit.sv
// -----------------------------------------------------------------------------
// tb_cp_xf_load_unit : self-checking bench for cp_xf_load_unit.
// -----------------------------------------------------------------------------
module tb_cp_xf_load_unit;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  cp_xf_load_unit_if #(.ADDR_W(16)) u_if ();

  cp_xf_load_unit #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (u_if),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Entry: {last, addr[15:0], data[31:0]}
  logic [48:0] exp_q[$];
  logic [31:0] tx_words[$];

  // Expected writes follow from the header alone: N = count+1 words at
  // consecutive addresses modulo 2^16, the last one flagged done.
  task automatic model_cmd(input logic [31:0] hdr);
    int n;
    int a;
    n = int'(hdr[31:16]) + 1;
    for (int j = 0; j < n; j++) begin
      a = (int'(hdr[15:0]) + j) % 65536;
      exp_q.push_back({(j == n - 1), a[15:0], tx_words[j]});
    end
  endtask

  int          cyc = 0;
  int          mon_idx = 0;
  int          last_cyc = 0;
  bit          spacing_en = 1'b0;
  logic [15:0] mon_first = '0;
  logic [15:0] mon_last = '0;
  logic [48:0] mon_e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (u_if.CPWrite) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("cp_addr", u_if.CPAddr, mon_e[47:32]);
        check("cp_data", u_if.CPWriteData, mon_e[31:0]);
        check("done_flag", u_if.done, mon_e[48]);
        if (mon_e[48]) check("in_ready_at_done", u_if.in_ready, 0);
        if (spacing_en && mon_idx > 0) check("write_spacing", cyc - last_cyc, 4);
        if (mon_idx == 0) mon_first = u_if.CPAddr;
        mon_last = u_if.CPAddr;
        last_cyc = cyc;
        mon_idx++;
      end
    end else if (u_if.done) begin
      check("done_without_write", 1, 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit pulse_start);
    int g;
    bit acc;
    int tries;
    g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    if (g > 0) begin
      u_if.in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    u_if.in_valid = 1'b1;
    u_if.in_data  = b;
    u_if.start    = pulse_start;
    acc = 1'b0;
    tries = 0;
    // in_ready only changes on the rising edge, so its value now is what the
    // next edge will see.
    while (!acc && tries < 200) begin
      acc = u_if.in_ready;
      @(negedge clk);
      u_if.start = 1'b0;
      tries++;
    end
    if (!acc) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(w[31 - 8*k -: 8], maxgap, 1'b0);
  endtask

  task automatic do_start();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  // Runs one command with the words in tx_words. pulse_byte >= 0 raises start
  // together with that data byte.
  task automatic run_cmd(input string tag, input logic [31:0] hdr, input int maxgap,
                         input bit with_start, input int pulse_byte, input bit spacing,
                         input logic [15:0] exp_first, input logic [15:0] exp_last);
    int tries;
    int k;
    mon_idx = 0;
    spacing_en = spacing;
    model_cmd(hdr);
    if (with_start) do_start();
    send_word(hdr, maxgap);
    k = 0;
    foreach (tx_words[w]) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(tx_words[w][31 - 8*b -: 8], maxgap, (k == pulse_byte));
        if (k == pulse_byte) begin
          check("start_ignored_state", dbg_state, S_DATA);
          check("start_ignored_busy", u_if.busy, 1);
        end
        k++;
      end
    end
    u_if.in_valid = 1'b0;
    #1;
    tries = 0;
    while (exp_q.size() != 0 && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_first_addr"}, mon_first, exp_first);
    check({tag, "_last_addr"}, mon_last, exp_last);
    @(negedge clk);
    check({tag, "_busy_after"}, u_if.busy, 0);
    check({tag, "_state_after"}, dbg_state, S_IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, u_if.in_ready, 0);
    check({tag, "_busy"}, u_if.busy, 0);
    check({tag, "_done"}, u_if.done, 0);
    check({tag, "_cpwrite"}, u_if.CPWrite, 0);
    check({tag, "_cpaddr"}, u_if.CPAddr, 0);
    check({tag, "_cpdata"}, u_if.CPWriteData, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] hdr;
    logic [31:0] w0;
    logic [31:0] step;
    int          maxgap;
    bit          spacing;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] hdr;
    logic [15:0] base;
    int          n;
    int          la;

    u_if.start    = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;

    vecs[0] = '{hdr: 32'h0000_1000, w0: 32'hDEAD_BEEF, step: 32'h0,
                maxgap: 0, spacing: 1'b0, exp_first: 16'h1000, exp_last: 16'h1000};
    vecs[1] = '{hdr: 32'h0003_1020, w0: 32'h1111_1111, step: 32'h1111_1111,
                maxgap: 0, spacing: 1'b1, exp_first: 16'h1020, exp_last: 16'h1023};
    vecs[2] = '{hdr: 32'h0001_FFFF, w0: 32'hCAFE_0001, step: 32'h1,
                maxgap: 0, spacing: 1'b1, exp_first: 16'hFFFF, exp_last: 16'h0000};
    vecs[3] = '{hdr: 32'h0002_0005, w0: 32'h0102_0304, step: 32'h1010_1010,
                maxgap: 3, spacing: 1'b0, exp_first: 16'h0005, exp_last: 16'h0007};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Table: vector 0 is entered with a byte offered alongside start in IDLE.
    for (int i = 0; i < 4; i++) begin
      tx_words.delete();
      for (int j = 0; j <= int'(vecs[i].hdr[31:16]); j++)
        tx_words.push_back(vecs[i].w0 + 32'(j) * vecs[i].step);
      if (i == 0) begin
        u_if.start    = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'hAA;
        check("idle_in_ready_at_start", u_if.in_ready, 0);
        @(negedge clk);
        u_if.start    = 1'b0;
        u_if.in_valid = 1'b0;
        check("state_after_start", dbg_state, S_HDR);
        run_cmd($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].maxgap, 1'b0, -1,
                vecs[i].spacing, vecs[i].exp_first, vecs[i].exp_last);
      end else begin
        run_cmd($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].maxgap, 1'b1, -1,
                vecs[i].spacing, vecs[i].exp_first, vecs[i].exp_last);
      end
    end

    // start pulsed during DATA must not disturb the command.
    tx_words.delete();
    tx_words.push_back(32'hA5A5_0001);
    tx_words.push_back(32'h5A5A_0002);
    run_cmd("midstart", 32'h0001_4000, 0, 1'b1, 2, 1'b0, 16'h4000, 16'h4001);

    // Abort: reset after two data bytes of a one-word command.
    do_start();
    send_word(32'h0000_1000, 0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    u_if.in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("abort_no_pending", exp_q.size(), 0);

    // Command after abort.
    tx_words.delete();
    tx_words.push_back(32'h0BAD_F00D);
    run_cmd("post_abort", 32'h0000_0042, 0, 1'b1, -1, 1'b0, 16'h0042, 16'h0042);

    // Randomized commands with random stalls, some wrapping past 0xFFFF.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(5, 1);
      base = ($urandom_range(1, 0) == 1) ? 16'(16'hFFFF - 16'($urandom_range(3, 0)))
                                         : 16'($urandom_range(16'hFFFF, 0));
      hdr = {16'(n - 1), base};
      tx_words.delete();
      for (int j = 0; j < n; j++) tx_words.push_back($urandom);
      la = (int'(base) + n - 1) % 65536;
      run_cmd($sformatf("rand%0d", r), hdr, 3, 1'b1, -1, 1'b0, base, la[15:0]);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
